// File: rtl/wall_follower_ctrl_if.sv
// wall_follower_ctrl_if: sensor inputs (head, left) and drive/status outputs (front, rotate, stuck, state[, steps when WF_STEP_COUNT_EN]) of wall_follower_ctrl
interface wall_follower_ctrl_if #(parameter int CNT_W = 16);
  logic head;
  logic left;
  logic front;
  logic rotate;
  logic stuck;
  logic [2:0] state;
`ifdef WF_STEP_COUNT_EN
  logic [CNT_W-1:0] steps;
  modport master (output head, left, input front, rotate, stuck, state, steps);
  modport slave (input head, left, output front, rotate, stuck, state, steps);
`else
  modport master (output head, left, input front, rotate, stuck, state);
  modport slave (input head, left, output front, rotate, stuck, state);
`endif
endinterface

// File: rtl/wall_follower_ctrl.sv
// wall_follower_ctrl: debounced head/left wall-following FSM; ports clk, reset (sync active-high), bus.slave (head,left in; front,rotate,stuck,state[2:0] out; steps[CNT_W-1:0] out when WF_STEP_COUNT_EN is defined)
module wall_follower_ctrl #(
  parameter int DEBOUNCE = 2,
  parameter int ROT_MAX = 16,
  parameter int TURN_CYCLES = 4,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic reset,
  wall_follower_ctrl_if.slave bus
);
  typedef enum logic [2:0] {SEARCH, FOLLOW, ROTATE, RESET_ROUTE, STUCK} st_e;
  localparam logic [7:0] DM = 8'(DEBOUNCE - 1);
  localparam logic [15:0] RM = 16'(ROT_MAX - 1);
  localparam logic [15:0] TM = 16'(TURN_CYCLES - 1);
  st_e st, ns;
  logic [1:0] raw, flt;
  logic [7:0] run [2];
  logic [15:0] rot_cnt, turn_cnt;
  logic front, rotate, stuck, go;
  assign raw = {bus.head, bus.left};
  assign go = flt == 2'b01;
  assign bus.front = front;
  assign bus.rotate = rotate;
  assign bus.stuck = stuck;
  assign bus.state = st;
  always_comb begin
    ns = SEARCH;
    case (st)
      SEARCH: ns = go ? FOLLOW : flt[1] ? ROTATE : SEARCH;
      FOLLOW: ns = go ? FOLLOW : flt == 2'b11 ? ROTATE : RESET_ROUTE;
      ROTATE: ns = go ? FOLLOW : rot_cnt == RM ? STUCK : ROTATE;
      RESET_ROUTE: ns = go ? FOLLOW : flt[1] ? ROTATE : turn_cnt == TM ? SEARCH : RESET_ROUTE;
      STUCK: ns = STUCK;
      default: ns = SEARCH;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= SEARCH;
      flt <= '0;
      run[0] <= '0;
      run[1] <= '0;
      rot_cnt <= '0;
      turn_cnt <= '0;
      front <= 1'b1;
      rotate <= 1'b0;
      stuck <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        run[i] <= (raw[i] != flt[i] && run[i] != DM) ? run[i] + 8'd1 : '0;
        if (raw[i] != flt[i] && run[i] == DM) flt[i] <= raw[i];
      end
      st <= ns;
      rot_cnt <= (st == ROTATE && ns == ROTATE) ? rot_cnt + 16'd1 : '0;
      turn_cnt <= (st == RESET_ROUTE && ns == RESET_ROUTE) ? turn_cnt + 16'd1 : '0;
      front <= ns == SEARCH || ns == FOLLOW;
      rotate <= ns == ROTATE || ns == RESET_ROUTE;
      stuck <= ns == STUCK;
    end
  end
`ifdef WF_STEP_COUNT_EN
  logic [CNT_W-1:0] steps;
  assign bus.steps = steps;
  always_ff @(posedge clk)
    steps <= reset ? '0 : (front && steps != '1) ? steps + CNT_W'(1) : steps;
`endif
endmodule
